// File: rtl/dab_mod_sequencer.sv
// rtl/dab_mod_sequencer.sv - run-time command sequencer for the DAB modulation datapath
//
// Sits between the command side and the modulator. Commands arrive on a
// valid/ready handshake, are clamped into shadow registers, and are released
// to the modulator only on switching-period boundaries (period_tick). t1/t2
// ramp up from zero after enable (soft start); phi is optionally slew-limited.
// A fault forces the converter off until acknowledged with enable low.
//
// Build option:
//   DAB_PHI_SLEW_EN  when defined, phi moves at most PHI_STEP per RUN period;
//                    when undefined, phi loads its target on the period tick.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             run request
//   fault, fault_clr   external fault and its acknowledge
//   period_tick        one-cycle pulse at the start of each switching period
//   cmd_valid/ready    command handshake
//   cmd_t1, cmd_t2     requested t1/t2 (9-bit signed)
//   cmd_phi            requested phase shift (9-bit signed)
//   cmd_fs             requested switching frequency in Hz (19-bit signed)
//   cmd_deadtime       requested deadtime
//   t1, t2, phi        applied modulation values (registered)
//   fs_DAB, deadtime   applied frequency / deadtime (registered)
//   sync               modulator run/fire enable
//   state              IDLE=00, SOFT=01, RUN=10, FAULT=11
//   fault_latched      high while in FAULT

module dab_mod_sequencer #(
    parameter int SOFT_STEP = 16,
    parameter int PHI_STEP  = 4,
    parameter int DT_MIN    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fault,
    input  logic               fault_clr,
    input  logic               period_tick,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic signed [8:0]  cmd_t1,
    input  logic signed [8:0]  cmd_t2,
    input  logic signed [8:0]  cmd_phi,
    input  logic signed [18:0] cmd_fs,
    input  logic [7:0]         cmd_deadtime,
    output logic signed [8:0]  t1,
    output logic signed [8:0]  t2,
    output logic signed [8:0]  phi,
    output logic signed [18:0] fs_DAB,
    output logic [7:0]         deadtime,
    output logic               sync,
    output logic [1:0]         state,
    output logic               fault_latched
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SOFT  = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

`ifdef DAB_PHI_SLEW_EN
    localparam bit PHI_SLEW = 1'b1;
`else
    localparam bit PHI_SLEW = 1'b0;
`endif

    // Without slew limiting the phi limit exceeds any possible |delta| (max 510),
    // so the shared step logic degenerates into a direct load.
    localparam int PHI_LIM_I = PHI_SLEW ? PHI_STEP : 511;

    localparam logic signed [9:0]  SOFT_LIM  = 10'(SOFT_STEP);
    localparam logic signed [9:0]  PHI_LIM   = 10'(PHI_LIM_I);
    localparam logic [7:0]         DT_FLOOR  = 8'(DT_MIN);
    localparam logic signed [18:0] FS_MAX    = 19'sd150000;
    localparam logic signed [8:0]  PHI_FLOOR = -9'sd255;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // A non-negative 9-bit signed value can never exceed 255, so only the
    // lower bound needs handling.
    function automatic logic signed [8:0] clamp_t(input logic signed [8:0] v);
        return v[8] ? 9'sd0 : v;
    endfunction

    // Only -256 lies outside [-255,255].
    function automatic logic signed [8:0] clamp_phi(input logic signed [8:0] v);
        return (v < PHI_FLOOR) ? PHI_FLOOR : v;
    endfunction

    function automatic logic signed [18:0] clamp_fs(input logic signed [18:0] v);
        logic signed [18:0] r;
        if (v[18])
            r = 19'sd0;
        else if (v > FS_MAX)
            r = FS_MAX;
        else
            r = v;
        return r;
    endfunction

    function automatic logic [7:0] clamp_dt(input logic [7:0] v);
        return (v < DT_FLOOR) ? DT_FLOOR : v;
    endfunction

    // Move cur toward tgt by at most lim, landing exactly on tgt when close.
    // Done in 10 bits so tgt - cur (up to +/-510) cannot wrap.
    function automatic logic signed [8:0] step_toward(
        input logic signed [8:0] cur,
        input logic signed [8:0] tgt,
        input logic signed [9:0] lim
    );
        logic signed [9:0] cur_w;
        logic signed [9:0] diff;
        logic signed [9:0] nxt;
        cur_w = $signed({cur[8], cur});
        diff  = $signed({tgt[8], tgt}) - cur_w;
        if (diff > lim)
            nxt = cur_w + lim;
        else if (diff < -lim)
            nxt = cur_w - lim;
        else
            nxt = $signed({tgt[8], tgt});
        return nxt[8:0];
    endfunction

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------

    logic [1:0]         state_nxt;

    logic signed [8:0]  sh_t1;
    logic signed [8:0]  sh_t2;
    logic signed [8:0]  sh_phi;
    logic signed [18:0] sh_fs;
    logic [7:0]         sh_dt;
    logic               have_cmd;
    logic               pending;

    logic               accept;
    logic signed [8:0]  c_t1;
    logic signed [8:0]  c_t2;
    logic signed [8:0]  c_phi;
    logic signed [18:0] c_fs;
    logic [7:0]         c_dt;

    logic signed [8:0]  eff_t1;
    logic signed [8:0]  eff_t2;
    logic signed [18:0] eff_fs;
    logic [7:0]         eff_dt;

    logic signed [8:0]  soft_t1;
    logic signed [8:0]  soft_t2;
    logic               soft_done;
    logic signed [8:0]  run_phi;

    logic signed [8:0]  t1_nxt;
    logic signed [8:0]  t2_nxt;
    logic signed [8:0]  phi_nxt;
    logic signed [18:0] fs_nxt;
    logic [7:0]         dt_nxt;
    logic               sync_nxt;
    logic               ready_nxt;
    logic               flt_nxt;
    logic               pending_nxt;

    assign accept = cmd_valid & cmd_ready;

    assign c_t1  = clamp_t(cmd_t1);
    assign c_t2  = clamp_t(cmd_t2);
    assign c_phi = clamp_phi(cmd_phi);
    assign c_fs  = clamp_fs(cmd_fs);
    assign c_dt  = clamp_dt(cmd_deadtime);

    // Values that tracking paths (IDLE/SOFT) should present next cycle: a
    // command accepted now takes effect without waiting for the shadow copy.
    assign eff_t1 = accept ? c_t1 : sh_t1;
    assign eff_t2 = accept ? c_t2 : sh_t2;
    assign eff_fs = accept ? c_fs : sh_fs;
    assign eff_dt = accept ? c_dt : sh_dt;

    assign soft_t1   = step_toward(t1, eff_t1, SOFT_LIM);
    assign soft_t2   = step_toward(t2, eff_t2, SOFT_LIM);
    assign soft_done = (soft_t1 == eff_t1) && (soft_t2 == eff_t2);

    // RUN updates use the shadow as it stood before this cycle, so a command
    // accepted on the tick cycle waits for the following tick.
    assign run_phi = step_toward(phi, sh_phi, PHI_LIM);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (fault > !enable > normal)
    // ------------------------------------------------------------------

    always_comb begin
        state_nxt = state;
        if (fault) begin
            state_nxt = S_FAULT;
        end else if (state == S_FAULT) begin
            if (fault_clr && !enable)
                state_nxt = S_IDLE;
        end else if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (have_cmd) state_nxt = S_SOFT;
                S_SOFT:  if (period_tick && soft_done) state_nxt = S_RUN;
                default: state_nxt = state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------

    always_comb begin
        t1_nxt      = t1;
        t2_nxt      = t2;
        phi_nxt     = phi;
        fs_nxt      = fs_DAB;
        dt_nxt      = deadtime;
        sync_nxt    = 1'b0;
        ready_nxt   = 1'b1;
        flt_nxt     = 1'b0;
        pending_nxt = pending;

        case (state_nxt)
            S_IDLE: begin
                t1_nxt      = 9'sd0;
                t2_nxt      = 9'sd0;
                phi_nxt     = 9'sd0;
                fs_nxt      = eff_fs;
                dt_nxt      = eff_dt;
                pending_nxt = 1'b0;
            end

            S_SOFT: begin
                sync_nxt = 1'b1;
                phi_nxt  = 9'sd0;
                fs_nxt   = eff_fs;
                dt_nxt   = eff_dt;
                if (state == S_SOFT && period_tick) begin
                    t1_nxt = soft_t1;
                    t2_nxt = soft_t2;
                end
            end

            S_RUN: begin
                sync_nxt = 1'b1;
                if (state == S_SOFT) begin
                    // Final ramp tick: outputs land on their targets.
                    t1_nxt  = soft_t1;
                    t2_nxt  = soft_t2;
                    phi_nxt = 9'sd0;
                    fs_nxt  = eff_fs;
                    dt_nxt  = eff_dt;
                end else if (period_tick) begin
                    t1_nxt  = sh_t1;
                    t2_nxt  = sh_t2;
                    phi_nxt = run_phi;
                    fs_nxt  = sh_fs;
                    dt_nxt  = sh_dt;
                end

                if (accept)
                    pending_nxt = 1'b1;
                else if (state == S_RUN && period_tick)
                    pending_nxt = 1'b0;
                ready_nxt = !pending_nxt;
            end

            default: begin
                t1_nxt    = 9'sd0;
                t2_nxt    = 9'sd0;
                phi_nxt   = 9'sd0;
                ready_nxt = 1'b0;
                flt_nxt   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and bookkeeping registers
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            t1            <= 9'sd0;
            t2            <= 9'sd0;
            phi           <= 9'sd0;
            fs_DAB        <= 19'sd0;
            deadtime      <= DT_FLOOR;
            sync          <= 1'b0;
            cmd_ready     <= 1'b1;
            fault_latched <= 1'b0;
            pending       <= 1'b0;
        end else begin
            t1            <= t1_nxt;
            t2            <= t2_nxt;
            phi           <= phi_nxt;
            fs_DAB        <= fs_nxt;
            deadtime      <= dt_nxt;
            sync          <= sync_nxt;
            cmd_ready     <= ready_nxt;
            fault_latched <= flt_nxt;
            pending       <= pending_nxt;
        end
    end

    // Shadow registers capture every accepted command, whatever the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_t1    <= 9'sd0;
            sh_t2    <= 9'sd0;
            sh_phi   <= 9'sd0;
            sh_fs    <= 19'sd0;
            sh_dt    <= DT_FLOOR;
            have_cmd <= 1'b0;
        end else if (accept) begin
            sh_t1    <= c_t1;
            sh_t2    <= c_t2;
            sh_phi   <= c_phi;
            sh_fs    <= c_fs;
            sh_dt    <= c_dt;
            have_cmd <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dab_mod_sequencer.sv
// tb/tb_dab_mod_sequencer.sv - scoreboard bench for dab_mod_sequencer
`timescale 1ns/1ps

module tb_dab_mod_sequencer;

`ifdef DAB_PHI_SLEW_EN
    localparam int PHI_LIM = 4;
`else
    localparam int PHI_LIM = 511;
`endif
    localparam int SOFT = 16;

    localparam int ST_IDLE  = 0;
    localparam int ST_SOFT  = 1;
    localparam int ST_RUN   = 2;
    localparam int ST_FAULT = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               fault;
    logic               fault_clr;
    logic               period_tick;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [8:0]  cmd_t1;
    logic signed [8:0]  cmd_t2;
    logic signed [8:0]  cmd_phi;
    logic signed [18:0] cmd_fs;
    logic [7:0]         cmd_deadtime;
    logic signed [8:0]  t1;
    logic signed [8:0]  t2;
    logic signed [8:0]  phi;
    logic signed [18:0] fs_DAB;
    logic [7:0]         deadtime;
    logic               sync;
    logic [1:0]         state;
    logic               fault_latched;

    always #5 clk = ~clk;

    dab_mod_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .period_tick   (period_tick),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_t1        (cmd_t1),
        .cmd_t2        (cmd_t2),
        .cmd_phi       (cmd_phi),
        .cmd_fs        (cmd_fs),
        .cmd_deadtime  (cmd_deadtime),
        .t1            (t1),
        .t2            (t2),
        .phi           (phi),
        .fs_DAB        (fs_DAB),
        .deadtime      (deadtime),
        .sync          (sync),
        .state         (state),
        .fault_latched (fault_latched)
    );

    typedef enum int {F_T1, F_T2, F_PHI, F_FS, F_DT, F_SYNC, F_STATE, F_READY, F_FLT} fld_e;

    typedef struct {
        string tag;
        fld_e  fld;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_t1;
    int   m_t2;
    int   m_phi;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int observe(input fld_e f);
        case (f)
            F_T1:    return int'(t1);
            F_T2:    return int'(t2);
            F_PHI:   return int'(phi);
            F_FS:    return int'(fs_DAB);
            F_DT:    return int'(deadtime);
            F_SYNC:  return int'(sync);
            F_STATE: return int'(state);
            F_READY: return int'(cmd_ready);
            default: return int'(fault_latched);
        endcase
    endfunction

    function automatic int toward(input int cur, input int tgt, input int lim);
        if (tgt - cur > lim)  return cur + lim;
        if (cur - tgt > lim)  return cur - lim;
        return tgt;
    endfunction

    task automatic push_exp(input string tag, input fld_e f, input int v);
        exp_t e;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // One clock; everything queued for this cycle is compared 1 ns after the edge.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.fld), e.val);
        end
    endtask

    task automatic gap();
        period_tick = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic set_cmd(input int a, input int b, input int p, input int f, input int d);
        cmd_t1       = 9'(a);
        cmd_t2       = 9'(b);
        cmd_phi      = 9'(p);
        cmd_fs       = 19'(f);
        cmd_deadtime = 8'(d);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst = 1'b1; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        period_tick = 1'b0; cmd_valid = 1'b0;
        set_cmd(0, 0, 0, 0, 0);

        // Reset state
        push_exp("rst_state", F_STATE, ST_IDLE);
        push_exp("rst_ready", F_READY, 1);
        push_exp("rst_dt", F_DT, 8);
        push_exp("rst_sync", F_SYNC, 0);
        push_exp("rst_t1", F_T1, 0);
        push_exp("rst_phi", F_PHI, 0);
        push_exp("rst_fs", F_FS, 0);
        push_exp("rst_flt", F_FLT, 0);
        cyc();

        // Accept in IDLE: fs/deadtime follow one cycle later
        rst = 1'b0;
        set_cmd(100, 100, 50, 50000, 20);
        cmd_valid = 1'b1;
        push_exp("idle_fs", F_FS, 50000);
        push_exp("idle_dt", F_DT, 20);
        push_exp("idle_state", F_STATE, ST_IDLE);
        push_exp("idle_t1", F_T1, 0);
        cyc();
        cmd_valid = 1'b0;

        enable = 1'b1;
        push_exp("soft_entry_state", F_STATE, ST_SOFT);
        push_exp("soft_entry_sync", F_SYNC, 1);
        push_exp("soft_entry_t1", F_T1, 0);
        cyc();

        // Soft start: 16,32,...,96,100 then RUN
        m_t1 = 0; m_t2 = 0;
        for (int k = 1; k <= 7; k++) begin
            period_tick = 1'b1;
            m_t1 = toward(m_t1, 100, SOFT);
            m_t2 = toward(m_t2, 100, SOFT);
            push_exp("soft_t1", F_T1, m_t1);
            push_exp("soft_t2", F_T2, m_t2);
            push_exp("soft_phi", F_PHI, 0);
            push_exp("soft_state", F_STATE, (k == 7) ? ST_RUN : ST_SOFT);
            cyc();
            gap();
        end

        // phi slew in RUN
        m_phi = 0;
        for (int j = 1; j <= 13; j++) begin
            period_tick = 1'b1;
            m_phi = toward(m_phi, 50, PHI_LIM);
            push_exp("run_phi", F_PHI, m_phi);
            push_exp("run_t1", F_T1, 100);
            cyc();
            gap();
        end
        push_exp("run_phi_final", F_PHI, 50);
        push_exp("run_state", F_STATE, ST_RUN);
        cyc();

        // Mid-period update: held off until the next tick
        set_cmd(100, 100, -30, 50000, 20);
        cmd_valid = 1'b1;
        push_exp("upd_ready_lo", F_READY, 0);
        push_exp("upd_phi_hold", F_PHI, 50);
        cyc();
        cmd_valid = 1'b0;
        push_exp("upd_ready_lo2", F_READY, 0);
        push_exp("upd_phi_hold2", F_PHI, 50);
        cyc();
        period_tick = 1'b1;
        m_phi = toward(m_phi, -30, PHI_LIM);
        push_exp("upd_phi_step", F_PHI, m_phi);
        push_exp("upd_ready_hi", F_READY, 1);
        cyc();
        gap();
        for (int j = 0; j < 40 && m_phi != -30; j++) begin
            period_tick = 1'b1;
            m_phi = toward(m_phi, -30, PHI_LIM);
            push_exp("upd_phi", F_PHI, m_phi);
            cyc();
            gap();
        end

        // Tick and accept in the same cycle: applied only by the next tick
        set_cmd(60, 80, -30, 40000, 30);
        cmd_valid = 1'b1;
        period_tick = 1'b1;
        push_exp("same_t1", F_T1, 100);
        push_exp("same_t2", F_T2, 100);
        push_exp("same_fs", F_FS, 50000);
        push_exp("same_dt", F_DT, 20);
        push_exp("same_ready", F_READY, 0);
        cyc();
        cmd_valid = 1'b0;
        period_tick = 1'b0;
        push_exp("same_ready2", F_READY, 0);
        push_exp("same_t1_hold", F_T1, 100);
        cyc();
        cyc();
        period_tick = 1'b1;
        push_exp("next_t1", F_T1, 60);
        push_exp("next_t2", F_T2, 80);
        push_exp("next_fs", F_FS, 40000);
        push_exp("next_dt", F_DT, 30);
        push_exp("next_phi", F_PHI, -30);
        push_exp("next_ready", F_READY, 1);
        cyc();
        gap();

        // Clamping
        set_cmd(-7, 255, -256, 200000, 2);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        period_tick = 1'b1;
        m_phi = toward(m_phi, -255, PHI_LIM);
        push_exp("clamp_t1", F_T1, 0);
        push_exp("clamp_t2", F_T2, 255);
        push_exp("clamp_fs", F_FS, 150000);
        push_exp("clamp_dt", F_DT, 8);
        push_exp("clamp_phi", F_PHI, m_phi);
        cyc();
        gap();
        for (int j = 0; j < 80 && m_phi != -255; j++) begin
            period_tick = 1'b1;
            m_phi = toward(m_phi, -255, PHI_LIM);
            push_exp("clamp_phi_ramp", F_PHI, m_phi);
            cyc();
            gap();
        end

        // enable low -> IDLE
        enable = 1'b0;
        push_exp("dis_state", F_STATE, ST_IDLE);
        push_exp("dis_sync", F_SYNC, 0);
        push_exp("dis_t1", F_T1, 0);
        push_exp("dis_t2", F_T2, 0);
        push_exp("dis_phi", F_PHI, 0);
        push_exp("dis_ready", F_READY, 1);
        push_exp("dis_fs", F_FS, 150000);
        push_exp("dis_dt", F_DT, 8);
        cyc();

        // Negative fs clamps to 0; deadtime above the floor passes through
        set_cmd(200, 40, 10, -5, 9);
        cmd_valid = 1'b1;
        push_exp("idle2_fs", F_FS, 0);
        push_exp("idle2_dt", F_DT, 9);
        cyc();
        cmd_valid = 1'b0;
        enable = 1'b1;
        push_exp("soft2_state", F_STATE, ST_SOFT);
        cyc();
        m_t1 = 0; m_t2 = 0;
        for (int k = 0; k < 3; k++) begin
            period_tick = 1'b1;
            m_t1 = toward(m_t1, 200, SOFT);
            m_t2 = toward(m_t2, 40, SOFT);
            push_exp("soft2_t1", F_T1, m_t1);
            push_exp("soft2_t2", F_T2, m_t2);
            cyc();
            gap();
        end

        // Fault during SOFT
        fault = 1'b1;
        push_exp("flt_state", F_STATE, ST_FAULT);
        push_exp("flt_sync", F_SYNC, 0);
        push_exp("flt_t1", F_T1, 0);
        push_exp("flt_t2", F_T2, 0);
        push_exp("flt_ready", F_READY, 0);
        push_exp("flt_latched", F_FLT, 1);
        cyc();
        fault = 1'b0;
        fault_clr = 1'b1;
        push_exp("flt_hold_state", F_STATE, ST_FAULT);
        push_exp("flt_hold_latched", F_FLT, 1);
        cyc();
        enable = 1'b0;
        push_exp("flt_exit_state", F_STATE, ST_IDLE);
        push_exp("flt_exit_latched", F_FLT, 0);
        push_exp("flt_exit_ready", F_READY, 1);
        push_exp("flt_exit_fs", F_FS, 0);
        push_exp("flt_exit_dt", F_DT, 9);
        cyc();
        fault_clr = 1'b0;

        // Ramp to RUN again, then reset together with a tick
        enable = 1'b1;
        push_exp("soft3_state", F_STATE, ST_SOFT);
        cyc();
        m_t1 = 0; m_t2 = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            period_tick = 1'b1;
            m_t1 = toward(m_t1, 200, SOFT);
            m_t2 = toward(m_t2, 40, SOFT);
            done = (m_t1 == 200) && (m_t2 == 40);
            push_exp("soft3_t1", F_T1, m_t1);
            push_exp("soft3_state", F_STATE, done ? ST_RUN : ST_SOFT);
            cyc();
            gap();
        end

        rst = 1'b1;
        period_tick = 1'b1;
        push_exp("rst_run_state", F_STATE, ST_IDLE);
        push_exp("rst_run_sync", F_SYNC, 0);
        push_exp("rst_run_dt", F_DT, 8);
        push_exp("rst_run_ready", F_READY, 1);
        push_exp("rst_run_t1", F_T1, 0);
        push_exp("rst_run_fs", F_FS, 0);
        push_exp("rst_run_flt", F_FLT, 0);
        cyc();
        rst = 1'b0;
        period_tick = 1'b0;
        push_exp("no_cmd_state", F_STATE, ST_IDLE);
        push_exp("no_cmd_sync", F_SYNC, 0);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
